// File: rtl/bitwise_pkg.sv
// Shared opcode constants and FSM state encoding for the bitwise logic unit.
package bitwise_pkg;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;
  localparam logic [1:0] OP_NOR = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/bitwise_logic_unit_if.sv
// Operand/result handshake bundle between a producer/consumer and the bitwise logic unit.
interface bitwise_logic_unit_if #(
  parameter int unsigned WIDTH = 32
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] data_operandA;
  logic [WIDTH-1:0] data_operandB;
  logic [1:0]       ctrl_opcode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             is_zero;

  modport master (
    output in_valid, data_operandA, data_operandB, ctrl_opcode, out_ready,
    input  in_ready, out_valid, result, is_zero
  );

  modport slave (
    input  in_valid, data_operandA, data_operandB, ctrl_opcode, out_ready,
    output in_ready, out_valid, result, is_zero
  );

endinterface

// File: rtl/bitwise_slice.sv
// Combinational SLICE-bit AND/OR/XOR/NOR datapath; bits are independent, no carries.
module bitwise_slice
  import bitwise_pkg::*;
#(
  parameter int unsigned SLICE = 8
) (
  input  logic [SLICE-1:0] a_i,
  input  logic [SLICE-1:0] b_i,
  input  logic [1:0]       op_i,
  output logic [SLICE-1:0] y_o
);

  always_comb begin
    y_o = '0;
    case (op_i)
      OP_AND:  y_o = a_i & b_i;
      OP_OR:   y_o = a_i | b_i;
      OP_XOR:  y_o = a_i ^ b_i;
      OP_NOR:  y_o = ~(a_i | b_i);
      default: y_o = '0;
    endcase
  end

endmodule

// File: rtl/bitwise_logic_unit.sv
// Multi-cycle bitwise logic unit: latches a bundle, builds the result SLICE bits per
// cycle through one shared slice datapath, then holds result/is_zero until consumed.
module bitwise_logic_unit
  import bitwise_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SLICE = 8
) (
  input logic                clock,
  input logic                reset,
  bitwise_logic_unit_if.slave bus
);

  localparam int unsigned N        = WIDTH / SLICE;
  localparam int unsigned IDX_W    = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  if (WIDTH % SLICE != 0) begin : g_bad_slice
    $error("bitwise_logic_unit: WIDTH must be a multiple of SLICE");
  end

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic [1:0]       op_q, op_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             zero_q, zero_d;
  logic [SLICE-1:0] a_sl, b_sl, y_sl;

  // Slice mux feeding the single shared datapath instance
  assign a_sl = a_q[idx_q*SLICE +: SLICE];
  assign b_sl = b_q[idx_q*SLICE +: SLICE];

  bitwise_slice #(.SLICE(SLICE)) u_slice (
    .a_i  (a_sl),
    .b_i  (b_sl),
    .op_i (op_q),
    .y_o  (y_sl)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    idx_d   = idx_q;
    res_d   = res_q;
    zero_d  = zero_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.data_operandA;
          b_d     = bus.data_operandB;
          op_d    = bus.ctrl_opcode;
          res_d   = '0;
          zero_d  = 1'b0;
          idx_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        res_d[idx_q*SLICE +: SLICE] = y_sl;
        if (idx_q == LAST_IDX) begin
          // Zero flag sees the final slice on the same edge it is written
          zero_d  = (res_d == '0);
          idx_d   = '0;
          state_d = DONE;
        end else begin
          idx_d = IDX_W'(idx_q + 1'b1);
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= OP_AND;
      idx_q   <= '0;
      res_q   <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      idx_q   <= idx_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.result    = res_q;
  assign bus.is_zero   = zero_q;

endmodule

// File: tb/tb_bitwise_logic_unit.sv
// Self-checking bench: a SLICE=8 and a SLICE=32 unit checked every cycle against a
// transaction-level model, plus directed scenarios with hand-computed expectations.
module tb_bitwise_logic_unit;
  import bitwise_pkg::*;

  logic clock = 1'b0;
  logic rst   = 1'b1;
  always #5 clock = ~clock;

  bitwise_logic_unit_if #(.WIDTH(32)) bus0 ();
  bitwise_logic_unit_if #(.WIDTH(32)) bus1 ();

  bitwise_logic_unit #(.WIDTH(32), .SLICE(8)) u_dut8 (
    .clock (clock),
    .reset (rst),
    .bus   (bus0.slave)
  );

  bitwise_logic_unit #(.WIDTH(32), .SLICE(32)) u_dut32 (
    .clock (clock),
    .reset (rst),
    .bus   (bus1.slave)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_op(input logic [1:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    case (op)
      2'd0:    return a & b;
      2'd1:    return a | b;
      2'd2:    return a ^ b;
      default: return ~(a | b);
    endcase
  endfunction

  // Transaction-level model: an accepted bundle appears as a finished result N cycles later
  typedef enum int {M_IDLE, M_BUSY, M_DONE} mph_t;
  mph_t        ph    [2];
  int          left  [2];
  int          nsl   [2] = '{4, 1};
  logic [31:0] pend  [2];
  logic [31:0] mres  [2];
  logic        mz    [2];
  bit          mchk  [2];
  logic        iv    [2];
  logic        ordy  [2];
  logic [31:0] ia    [2];
  logic [31:0] ib    [2];
  logic [1:0]  iop   [2];
  bit          model_live = 1'b0;

  always @(posedge clock) begin
    iv[0] = bus0.in_valid; ia[0] = bus0.data_operandA; ib[0] = bus0.data_operandB;
    iop[0] = bus0.ctrl_opcode; ordy[0] = bus0.out_ready;
    iv[1] = bus1.in_valid; ia[1] = bus1.data_operandA; ib[1] = bus1.data_operandB;
    iop[1] = bus1.ctrl_opcode; ordy[1] = bus1.out_ready;
    for (int u = 0; u < 2; u++) begin
      if (rst) begin
        ph[u] = M_IDLE; mres[u] = '0; mz[u] = 1'b0; mchk[u] = 1'b1; left[u] = 0;
      end else begin
        case (ph[u])
          M_IDLE: if (iv[u]) begin
            pend[u] = ref_op(iop[u], ia[u], ib[u]);
            left[u] = nsl[u];
            mchk[u] = 1'b0;
            ph[u]   = M_BUSY;
          end
          M_BUSY: begin
            left[u]--;
            if (left[u] == 0) begin
              mres[u] = pend[u]; mz[u] = (pend[u] == '0); mchk[u] = 1'b1;
              ph[u]   = M_DONE;
            end
          end
          default: if (ordy[u]) ph[u] = M_IDLE;
        endcase
      end
    end
    model_live = 1'b1;
  end

  always @(negedge clock) begin
    if (model_live) begin
      chk("u8 in_ready",   32'(bus0.in_ready),  32'(ph[0] == M_IDLE));
      chk("u8 out_valid",  32'(bus0.out_valid), 32'(ph[0] == M_DONE));
      chk("u32 in_ready",  32'(bus1.in_ready),  32'(ph[1] == M_IDLE));
      chk("u32 out_valid", 32'(bus1.out_valid), 32'(ph[1] == M_DONE));
      if (mchk[0]) begin
        chk("u8 result",  bus0.result,        mres[0]);
        chk("u8 is_zero", 32'(bus0.is_zero),  32'(mz[0]));
      end
      if (mchk[1]) begin
        chk("u32 result",  bus1.result,       mres[1]);
        chk("u32 is_zero", 32'(bus1.is_zero), 32'(mz[1]));
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic issue0(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    int k = 0;
    while (!bus0.in_ready && k < 50) begin step(); k++; end
    chk("u8 ready wait", 32'(bus0.in_ready), 32'd1);
    bus0.in_valid = 1'b1; bus0.ctrl_opcode = op;
    bus0.data_operandA = a; bus0.data_operandB = b;
    step();
    bus0.in_valid = 1'b0;
  endtask

  task automatic wait_done0(output int lat);
    lat = 0;
    while (!bus0.out_valid && lat < 100) begin step(); lat++; end
    chk("u8 done wait", 32'(bus0.out_valid), 32'd1);
  endtask

  int lat;
  int acc_cyc[$];

  initial begin
    bus0.in_valid = 1'b0; bus0.data_operandA = '0; bus0.data_operandB = '0;
    bus0.ctrl_opcode = OP_AND; bus0.out_ready = 1'b0;
    bus1.in_valid = 1'b0; bus1.data_operandA = '0; bus1.data_operandB = '0;
    bus1.ctrl_opcode = OP_AND; bus1.out_ready = 1'b1;
    rst = 1'b1;
    step(); step();
    rst = 1'b0;

    // AND with latency check
    bus0.out_ready = 1'b1;
    issue0(OP_AND, 32'hFFFF0000, 32'h0F0F0F0F);
    wait_done0(lat);
    chk("t1 latency", 32'(lat), 32'd4);
    chk("t1 result", bus0.result, 32'h0F0F0000);
    chk("t1 is_zero", 32'(bus0.is_zero), 32'd0);
    step();

    // XOR to zero, then NOR of zeros
    issue0(OP_XOR, 32'hDEADBEEF, 32'hDEADBEEF);
    wait_done0(lat);
    chk("t2 xor result", bus0.result, 32'h00000000);
    chk("t2 xor is_zero", 32'(bus0.is_zero), 32'd1);
    step();
    issue0(OP_NOR, 32'h0, 32'h0);
    wait_done0(lat);
    chk("t2 nor result", bus0.result, 32'hFFFFFFFF);
    chk("t2 nor is_zero", 32'(bus0.is_zero), 32'd0);
    step();

    // Backpressure with in_valid held high and operands changing
    bus0.out_ready = 1'b0;
    issue0(OP_OR, 32'h12340000, 32'h00005678);
    bus0.in_valid = 1'b1;
    bus0.data_operandA = $urandom(); bus0.data_operandB = $urandom();
    wait_done0(lat);
    for (int i = 0; i < 10; i++) begin
      chk("t3 held result", bus0.result, 32'h12345678);
      chk("t3 in_ready low", 32'(bus0.in_ready), 32'd0);
      bus0.data_operandA = $urandom(); bus0.data_operandB = $urandom();
      bus0.ctrl_opcode = 2'($urandom_range(0, 3));
      step();
    end
    bus0.out_ready = 1'b1;
    step();
    bus0.in_valid = 1'b0;
    chk("t3 in_ready after handshake", 32'(bus0.in_ready), 32'd1);
    chk("t3 out_valid after handshake", 32'(bus0.out_valid), 32'd0);

    // Operand change after accept has no effect
    issue0(OP_AND, 32'hF0F0F0F0, 32'hFF00FF00);
    bus0.data_operandA = '0; bus0.data_operandB = '0; bus0.ctrl_opcode = OP_OR;
    wait_done0(lat);
    chk("t4 latched result", bus0.result, 32'hF000F000);
    step();

    // Reset in the middle of an operation (slice index 2)
    issue0(OP_XOR, 32'h12345678, 32'hFFFFFFFF);
    step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t5 out_valid", 32'(bus0.out_valid), 32'd0);
    chk("t5 in_ready", 32'(bus0.in_ready), 32'd1);
    chk("t5 result", bus0.result, 32'd0);
    issue0(OP_AND, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done0(lat);
    chk("t5 fresh result", bus0.result, 32'hFFFFFFFF);
    step();

    // Reset wins over a simultaneous in_valid
    rst = 1'b1; bus0.in_valid = 1'b1;
    step();
    rst = 1'b0; bus0.in_valid = 1'b0;
    chk("reset beats in_valid", 32'(bus0.in_ready), 32'd1);
    step();
    chk("reset beats in_valid idle", 32'(bus0.in_ready), 32'd1);

    // SLICE == WIDTH: one-cycle latency, back-to-back throughput
    bus1.in_valid = 1'b1; bus1.out_ready = 1'b1; bus1.ctrl_opcode = OP_AND;
    bus1.data_operandA = 32'hA5A5A5A5; bus1.data_operandB = 32'h0FF00FF0;
    chk("t6 ready", 32'(bus1.in_ready), 32'd1);
    step();
    lat = 0;
    while (!bus1.out_valid && lat < 20) begin step(); lat++; end
    chk("t6 latency", 32'(lat), 32'd1);
    chk("t6 result", bus1.result, 32'h05A005A0);
    for (int c = 0; c < 18; c++) begin
      if (bus1.in_ready) acc_cyc.push_back(c);
      bus1.data_operandA = $urandom(); bus1.data_operandB = $urandom();
      step();
    end
    chk("t6 accept count", 32'(acc_cyc.size()), 32'd6);
    for (int i = 1; i < acc_cyc.size(); i++)
      chk("t6 interval", 32'(acc_cyc[i] - acc_cyc[i-1]), 32'd3);
    bus1.in_valid = 1'b0;
    step(); step();

    // Randomized traffic on both units, occasional reset
    for (int i = 0; i < 500; i++) begin
      rst = ($urandom_range(0, 59) == 0);
      bus0.in_valid = 1'($urandom_range(0, 1));
      bus0.out_ready = 1'($urandom_range(0, 2) != 0);
      bus0.ctrl_opcode = 2'($urandom_range(0, 3));
      bus0.data_operandA = $urandom();
      bus0.data_operandB = ($urandom_range(0, 3) == 0) ? bus0.data_operandA : $urandom();
      bus1.in_valid = 1'($urandom_range(0, 1));
      bus1.out_ready = 1'($urandom_range(0, 2) != 0);
      bus1.ctrl_opcode = 2'($urandom_range(0, 3));
      bus1.data_operandA = $urandom();
      bus1.data_operandB = ($urandom_range(0, 3) == 0) ? bus1.data_operandA : $urandom();
      step();
    end
    rst = 1'b0; bus0.in_valid = 1'b0; bus1.in_valid = 1'b0;
    bus0.out_ready = 1'b1; bus1.out_ready = 1'b1;
    repeat (8) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bitwise_logic_unit.md
# bitwise_logic_unit

Parametrised, multi-cycle successor to the combinational 32-bit AND stage. It latches two WIDTH-bit operands and a 2-bit opcode (AND/OR/XOR/NOR). It then processes the operands SLICE bits per cycle and presents a registered result with a zero flag behind a valid/ready handshake. It sits in the ALU's logic path, where area matters more than single-cycle latency.

## Interface
- WIDTH, 32: operand and result width in bits.
- SLICE, 8: bits processed per cycle; WIDTH % SLICE == 0 (elaboration-time assert). N = WIDTH/SLICE.
- clock  in  1  sole clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  operand/opcode bundle valid.
- in_ready  out  1  unit can accept a bundle.
- data_operandA  in  WIDTH  first operand.
- data_operandB  in  WIDTH  second operand.
- ctrl_opcode  in  2  00 AND, 01 OR, 10 XOR, 11 NOR.
- out_valid  out  1  result and zero flag valid.
- out_ready  in  1  consumer accepts the result.
- result  out  WIDTH  bitwise result.
- is_zero  out  1  result == 0.

## Operation
- States: IDLE, BUSY, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid && in_ready, latch A, B and opcode. Clear result. Set slice_idx = 0. Go to BUSY.
- BUSY:
  - Each cycle, compute bits [slice_idx*SLICE +: SLICE] with the latched opcode and write them into result.
  - slice_idx counts 0..N-1.
  - After writing slice N-1, go to DONE. Set is_zero from the full result (registered on the same edge).
- DONE:
  - out_valid = 1. result and is_zero are held stable.
  - On out_valid && out_ready, go to IDLE.
- in_ready is 1 only in IDLE. in_valid in BUSY or DONE is ignored, not queued.
- Operand and opcode inputs are sampled only on the accept edge. Later changes have no effect.
- NOR = ~(A|B) per bit. No other arithmetic; no carries between slices.
- Reset, at any time including mid-BUSY:
  - Next edge: state IDLE, slice_idx 0, result 0, is_zero 0, out_valid 0, in_ready 1.
  - Partial work is discarded.
- Reset and in_valid in the same cycle: reset wins; the bundle is not accepted.
- Illegal state encoding: recover to IDLE on the next edge.

## Timing
- Reset values: in_ready 1, out_valid 0, result 0, is_zero 0.
- Accept on edge E0:
  - BUSY occupies the cycles after edges E0..E(N-1).
  - out_valid rises after edge EN.
  - Latency is N cycles from accept to out_valid.
- SLICE == WIDTH: N = 1, and out_valid is high one cycle after accept.
- Result handshake on edge E: in_ready is high after E. The earliest next accept is edge E+1.
- Throughput with out_ready held high: one operation per N+2 cycles.
- result and is_zero are registered outputs; no combinational path from inputs to outputs.
- in_ready and out_valid are decoded from the state register only.

## Structure
- Shared package bitwise_pkg:
  - Opcode constants OP_AND=2'b00, OP_OR=2'b01, OP_XOR=2'b10, OP_NOR=2'b11.
  - State enum IDLE/BUSY/DONE.
- Sub-module bitwise_slice #(SLICE): combinational, computes one SLICE-bit result from two slices and the opcode. One instance, fed by a slice_idx-selected mux.
- Top level holds the FSM, the slice counter (width $clog2(N), minimum 1), the operand/opcode registers and the result register.

## Test plan
WIDTH=32, SLICE=8 unless noted.
1. AND, A=0xFFFF0000, B=0x0F0F0F0F, out_ready=1: out_valid rises exactly 4 cycles after accept; result=0x0F0F0000; is_zero=0.
2. XOR, A=B=0xDEADBEEF: result=0x00000000, is_zero=1. Then NOR with A=B=0: result=0xFFFFFFFF, is_zero=0.
3. Backpressure:
   - Stimulus: OR, A=0x12340000, B=0x00005678, out_ready=0 for 10 cycles, in_valid held high with new operands.
   - Required: result=0x12345678 stable, in_ready=0, no second accept.
   - After out_ready=1: one handshake, then in_ready=1.
4. Input change after accept: A changes to 0 during BUSY; result still reflects the latched A.
5. Reset mid-op: assert reset while slice_idx=2. Next cycle: out_valid=0, in_ready=1, result=0. A fresh AND of 0xFFFFFFFF and 0xFFFFFFFF completes with 0xFFFFFFFF.
6. SLICE=32, back-to-back AND ops with out_ready=1: latency 1 cycle, one result every 3 cycles, all values correct.
